// File: rtl/sd_adc_sched.sv
// sd_adc_sched: start-up sequencer and round-robin output arbiter for a bank
// of sigma-delta CIC decimators. Holds the filters in clear, discards their
// settling outputs, then captures one word per channel per output period and
// serialises the words onto a valid/ready stream tagged with the channel index.
module sd_adc_sched #(
    parameter int CH_NUM     = 4,
    parameter int CH_WIDTH   = $clog2(CH_NUM),
    parameter int RES_WIDTH  = 21,
    parameter int CLR_CYCLES = 2,
    parameter int SETTLE     = 3
) (
    input  logic                         clock,
    input  logic                         aclr,
    input  logic                         enable,
    output logic                         filt_sclr,
    input  logic [CH_NUM*RES_WIDTH-1:0]  filt_data,
    input  logic [CH_NUM-1:0]            filt_valid,
    output logic [RES_WIDTH-1:0]         out_data,
    output logic [CH_WIDTH-1:0]          out_ch,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CH_NUM-1:0]            overrun,
    input  logic                         ovr_clr,
    output logic                         running
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    // Counter load values; CLR_CYCLES counts down to zero, SETTLE counts up.
    localparam logic [3:0] CLR_LOAD = 4'(CLR_CYCLES - 1);
    localparam logic [3:0] SET_LAST = 4'(SETTLE - 1);

    state_t                 state_q;
    logic                   filt_sclr_q;
    logic                   running_q;
    logic [3:0]             clr_cnt_q;
    logic [3:0]             set_cnt_q;

    logic [RES_WIDTH-1:0]   hold_q [CH_NUM];
    logic [RES_WIDTH-1:0]   hold_d [CH_NUM];
    logic [CH_NUM-1:0]      pend_q, pend_d;
    logic [CH_WIDTH-1:0]    rr_q, rr_d;
    logic [CH_NUM-1:0]      ovr_q, ovr_d;
    logic [RES_WIDTH-1:0]   out_data_q, out_data_d;
    logic [CH_WIDTH-1:0]    out_ch_q, out_ch_d;
    logic                   out_valid_q, out_valid_d;

    logic                   to_idle_s;
    logic                   free_s;
    logic [CH_NUM-1:0]      cap_s;
    logic                   gnt_any_s;
    logic [CH_WIDTH-1:0]    gnt_idx_s;
    logic                   gnt_valid_s;
    logic [CH_NUM-1:0]      gnt_vec_s;
    logic [CH_NUM-1:0]      new_ovr_s;

    // Sequencer: clear the filters, drop settling pulses, then run.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q     <= ST_IDLE;
            filt_sclr_q <= 1'b1;
            running_q   <= 1'b0;
            clr_cnt_q   <= 4'd0;
            set_cnt_q   <= 4'd0;
        end else if (!enable) begin
            state_q     <= ST_IDLE;
            filt_sclr_q <= 1'b1;
            running_q   <= 1'b0;
            clr_cnt_q   <= 4'd0;
            set_cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q     <= ST_CLEAR;
                    filt_sclr_q <= 1'b1;
                    running_q   <= 1'b0;
                    clr_cnt_q   <= CLR_LOAD;
                    set_cnt_q   <= 4'd0;
                end
                ST_CLEAR: begin
                    if (clr_cnt_q == 4'd0) begin
                        filt_sclr_q <= 1'b0;
                        if (SETTLE == 0) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end else begin
                            state_q   <= ST_SETTLE;
                        end
                    end else begin
                        clr_cnt_q <= clr_cnt_q - 4'd1;
                    end
                end
                ST_SETTLE: begin
                    // The pulse that completes settling is itself discarded:
                    // capture only looks at state_q == ST_RUN.
                    if (filt_valid[0]) begin
                        if (set_cnt_q == SET_LAST) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                            set_cnt_q <= 4'd0;
                        end else begin
                            set_cnt_q <= set_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    filt_sclr_q <= 1'b1;
                    running_q   <= 1'b0;
                end
            endcase
        end
    end

    // Capture, overrun detection and round-robin grant for the next cycle.
    always_comb begin
        to_idle_s   = ~enable;
        free_s      = ~out_valid_q | out_ready;
        cap_s       = (state_q == ST_RUN) ? filt_valid : {CH_NUM{1'b0}};

        // First pending channel at or after rr_q, wrapping around.
        gnt_any_s   = 1'b0;
        gnt_idx_s   = {CH_WIDTH{1'b0}};
        for (int i = 0; i < CH_NUM; i++) begin
            if (!gnt_any_s && pend_q[(int'(rr_q) + i) % CH_NUM]) begin
                gnt_any_s = 1'b1;
                gnt_idx_s = CH_WIDTH'((int'(rr_q) + i) % CH_NUM);
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
        gnt_valid_s = free_s & gnt_any_s;

        for (int k = 0; k < CH_NUM; k++) begin
            gnt_vec_s[k] = gnt_valid_s && (int'(gnt_idx_s) == k);
            hold_d[k]    = cap_s[k] ? filt_data[k*RES_WIDTH +: RES_WIDTH] : hold_q[k];
        end

        // A re-capture on the granted channel is not a loss: the old word
        // leaves through the output register this very cycle.
        new_ovr_s = cap_s & pend_q & ~gnt_vec_s;
        ovr_d     = (ovr_clr ? {CH_NUM{1'b0}} : ovr_q) | new_ovr_s;

        if (to_idle_s) begin
            pend_d = {CH_NUM{1'b0}};
        end else begin
            pend_d = cap_s | (pend_q & ~gnt_vec_s);
        end

        if (to_idle_s) begin
            rr_d = {CH_WIDTH{1'b0}};
        end else if (gnt_valid_s) begin
            if (int'(gnt_idx_s) == CH_NUM - 1) begin
                rr_d = {CH_WIDTH{1'b0}};
            end else begin
                rr_d = gnt_idx_s + CH_WIDTH'(1);
            end
        end else begin
            rr_d = rr_q;
        end

        // The output word is held until it is accepted, even across a stop.
        if (gnt_valid_s) begin
            out_data_d  = hold_q[gnt_idx_s];
            out_ch_d    = gnt_idx_s;
            out_valid_d = 1'b1;
        end else if (free_s) begin
            out_data_d  = out_data_q;
            out_ch_d    = out_ch_q;
            out_valid_d = 1'b0;
        end else begin
            out_data_d  = out_data_q;
            out_ch_d    = out_ch_q;
            out_valid_d = out_valid_q;
        end
    end

    // Datapath registers: holding words, pend flags, pointer, output stage.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int k = 0; k < CH_NUM; k++) begin
                hold_q[k] <= {RES_WIDTH{1'b0}};
            end
            pend_q      <= {CH_NUM{1'b0}};
            rr_q        <= {CH_WIDTH{1'b0}};
            ovr_q       <= {CH_NUM{1'b0}};
            out_data_q  <= {RES_WIDTH{1'b0}};
            out_ch_q    <= {CH_WIDTH{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < CH_NUM; k++) begin
                hold_q[k] <= hold_d[k];
            end
            pend_q      <= pend_d;
            rr_q        <= rr_d;
            ovr_q       <= ovr_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign filt_sclr = filt_sclr_q;
    assign running   = running_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_sd_adc_sched.sv
// Bench for sd_adc_sched: start-up sequencing, round robin, backpressure,
// overrun handling and stop behaviour, with a scoreboard of expected words.
module tb_sd_adc_sched;

    localparam int CH_NUM    = 4;
    localparam int CH_WIDTH  = 2;
    localparam int RES_WIDTH = 21;

    logic                        clock = 1'b0;
    logic                        aclr;
    logic                        enable;
    logic                        filt_sclr;
    logic [CH_NUM*RES_WIDTH-1:0] filt_data;
    logic [CH_NUM-1:0]           filt_valid;
    logic [RES_WIDTH-1:0]        out_data;
    logic [CH_WIDTH-1:0]         out_ch;
    logic                        out_valid;
    logic                        out_ready;
    logic [CH_NUM-1:0]           overrun;
    logic                        ovr_clr;
    logic                        running;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [CH_WIDTH-1:0]  ch;
        logic [RES_WIDTH-1:0] data;
    } word_t;

    word_t exp_q[$];

    sd_adc_sched #(
        .CH_NUM(4), .CH_WIDTH(2), .RES_WIDTH(21), .CLR_CYCLES(2), .SETTLE(3)
    ) dut (
        .clock(clock), .aclr(aclr), .enable(enable), .filt_sclr(filt_sclr),
        .filt_data(filt_data), .filt_valid(filt_valid), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .ovr_clr(ovr_clr), .running(running)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int ch, input int data);
        word_t w;
        w.ch   = CH_WIDTH'(ch);
        w.data = RES_WIDTH'(data);
        exp_q.push_back(w);
    endtask

    // One-cycle strobe on the channels in mask with the given words.
    task automatic strobe(input logic [3:0] mask, input int d0, input int d1,
                          input int d2, input int d3);
        filt_data[0*RES_WIDTH +: RES_WIDTH] = RES_WIDTH'(d0);
        filt_data[1*RES_WIDTH +: RES_WIDTH] = RES_WIDTH'(d1);
        filt_data[2*RES_WIDTH +: RES_WIDTH] = RES_WIDTH'(d2);
        filt_data[3*RES_WIDTH +: RES_WIDTH] = RES_WIDTH'(d3);
        filt_valid = mask;
        tick();
        filt_valid = 4'b0000;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: a transfer happens at the next rising edge whenever
    // out_valid and out_ready are both high mid-cycle.
    always @(negedge clock) begin
        word_t w;
        if (!aclr && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_word", 32'(exp_q.size()), 32'd1);
            end else begin
                w = exp_q.pop_front();
                check_eq("out_ch", 32'(out_ch), 32'(w.ch));
                check_eq("out_data", 32'(out_data), 32'(w.data));
            end
        end
    end

    initial begin
        aclr       = 1'b1;
        enable     = 1'b0;
        filt_valid = 4'b0000;
        filt_data  = '0;
        out_ready  = 1'b1;
        ovr_clr    = 1'b0;
        #12;
        check_eq("rst_sclr", 32'(filt_sclr), 32'd1);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_ch", 32'(out_ch), 32'd0);
        check_eq("rst_ovr", 32'(overrun), 32'd0);
        check_eq("rst_running", 32'(running), 32'd0);
        aclr = 1'b0;
        tick();
        tick();

        // Start-up: sclr held exactly two cycles after leaving IDLE.
        enable = 1'b1;
        tick();
        check_eq("clr_cyc1", 32'(filt_sclr), 32'd1);
        tick();
        check_eq("clr_cyc2", 32'(filt_sclr), 32'd1);
        tick();
        check_eq("clr_done", 32'(filt_sclr), 32'd0);
        check_eq("settle_running", 32'(running), 32'd0);

        // Three settling pulses are dropped; running follows the third.
        for (int p = 0; p < 3; p++) begin
            repeat (127) tick();
            strobe(4'b1111, 32'hD00, 32'hD01, 32'hD02, 32'hD03);
            check_eq("running_settle", 32'(running), (p == 2) ? 32'd1 : 32'd0);
        end

        // Round robin on the fourth pulse.
        repeat (127) tick();
        push(0, 32'h10); push(1, 32'h20); push(2, 32'h30); push(3, 32'h40);
        strobe(4'b1111, 32'h10, 32'h20, 32'h30, 32'h40);
        check_eq("rr_lat_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("rr_valid", 32'(out_valid), 32'd1);
            check_eq("rr_ch", 32'(out_ch), 32'(i));
        end
        tick();
        check_eq("rr_idle", 32'(out_valid), 32'd0);
        check_eq("rr_ovr", 32'(overrun), 32'd0);

        // Backpressure over two further output periods.
        out_ready = 1'b0;
        push(0, 32'h100);
        strobe(4'b1111, 32'h100, 32'h101, 32'h102, 32'h103);
        tick();
        check_eq("bp_valid", 32'(out_valid), 32'd1);
        repeat (10) tick();
        strobe(4'b1111, 32'h200, 32'h201, 32'h202, 32'h203);
        repeat (10) tick();
        strobe(4'b1111, 32'h300, 32'h301, 32'h302, 32'h303);
        check_eq("bp_ovr", 32'(overrun), 32'hF);
        check_eq("bp_frozen_data", 32'(out_data), 32'h100);
        check_eq("bp_frozen_ch", 32'(out_ch), 32'd0);
        push(1, 32'h301); push(2, 32'h302); push(3, 32'h303); push(0, 32'h300);
        out_ready = 1'b1;
        drain();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check_eq("ovr_cleared", 32'(overrun), 32'd0);

        // Re-strobe of ch2 on the cycle ch2 is granted.
        push(1, 32'h501); push(2, 32'h502); push(3, 32'h503);
        push(0, 32'h500); push(2, 32'h5A2);
        strobe(4'b1111, 32'h500, 32'h501, 32'h502, 32'h503);
        tick();
        strobe(4'b0100, 32'h0, 32'h0, 32'h5A2, 32'h0);
        check_eq("same_ch", 32'(out_ch), 32'd2);
        check_eq("same_data", 32'(out_data), 32'h502);
        check_eq("same_ovr", 32'(overrun), 32'd0);
        drain();
        tick();

        // ovr_clr colliding with a new overrun on ch1.
        out_ready = 1'b0;
        push(3, 32'h603);
        strobe(4'b1111, 32'h600, 32'h601, 32'h602, 32'h603);
        tick();
        strobe(4'b1111, 32'h700, 32'h701, 32'h702, 32'h703);
        check_eq("pre_clr_ovr", 32'(overrun), 32'h7);
        ovr_clr = 1'b1;
        strobe(4'b0010, 32'h0, 32'h7F1, 32'h0, 32'h0);
        ovr_clr = 1'b0;
        check_eq("clr_collide_ovr", 32'(overrun), 32'h2);

        // Stop with a word held in the output register.
        enable = 1'b0;
        tick();
        check_eq("stop_sclr", 32'(filt_sclr), 32'd1);
        check_eq("stop_running", 32'(running), 32'd0);
        check_eq("stop_held_valid", 32'(out_valid), 32'd1);
        check_eq("stop_held_data", 32'(out_data), 32'h603);
        out_ready = 1'b1;
        tick();
        check_eq("stop_released", 32'(out_valid), 32'd0);
        repeat (5) tick();
        check_eq("stop_no_pend", 32'(out_valid), 32'd0);
        check_eq("stop_queue", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
